// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO, paced by an OVERSAMPLE x baud tick
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    baud_tick,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] sh, sh_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0] bidx, bidx_n;
  logic tx_n, push, pop, last;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign push = wr_en && !full;
  assign last = tcnt == TW'(OVERSAMPLE - 1);
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= wr_en && full;
    end
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      sh <= '0;
      tcnt <= '0;
      bidx <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      sh <= sh_n;
      tcnt <= tcnt_n;
      bidx <= bidx_n;
      tx <= tx_n;
    end
  // Serial state only moves on a tick; pops happen only at frame start
  always_comb begin
    state_n = state;
    sh_n = sh;
    tcnt_n = tcnt;
    bidx_n = bidx;
    tx_n = tx;
    pop = 1'b0;
    if (baud_tick) begin
      tcnt_n = tcnt + 1'b1;
      case (state)
        IDLE: begin
          tx_n = 1'b1;
          tcnt_n = '0;
          if (!empty) begin
            pop = 1'b1;
            sh_n = mem[rptr];
            tx_n = 1'b0;
            state_n = START;
          end
        end
        START: if (last) begin
          tcnt_n = '0;
          bidx_n = '0;
          tx_n = sh[0];
          state_n = DATA;
        end
        DATA: if (last) begin
          tcnt_n = '0;
          if (bidx == 3'd7) begin
            tx_n = 1'b1;
            state_n = STOP;
          end else begin
            sh_n = sh >> 1;
            tx_n = sh[1];
            bidx_n = bidx + 1'b1;
          end
        end
        default: if (last) begin
          tcnt_n = '0;
          if (!empty) begin
            pop = 1'b1;
            sh_n = mem[rptr];
            tx_n = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      endcase
    end
  end
endmodule
